seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//   Sequencer for the 10011 serial pattern detector. Accepts a frame of bytes over a
//   valid/ready stream and shifts them MSB-first, one bit per clk, onto the detector x input.
//   Owns the detector's reset, counts hits on z, raises an irq at a programmable threshold.
// PARAMETERS
//   DATA_W      8   bits per input word; shifted MSB first
//   FRAME_LEN_W 8   width of frame_len (words per frame, max 2^FRAME_LEN_W-1)
//   CNT_W       16  width of hit_cnt and irq_thresh
// PORTS
//   clk         in   1            clock
//   rst         in   1            async reset, active-low
//   start       in   1            start pulse; honoured only in IDLE with frame_len!=0
//   abort       in   1            sync abort; any state -> IDLE
//   frame_len   in   FRAME_LEN_W  words in frame; sampled on accepted start
//   in_valid    in   1            word available
//   in_data     in   DATA_W       word
//   in_ready    out  1            word accepted when in_valid && in_ready
//   det_x       out  1            serial bit to detector x
//   det_clr_n   out  1            detector rst (active-low); flop output, glitch-free
//   det_z       in   1            detector z (Moore, 1-cycle latency)
//   busy        out  1            state != IDLE
//   done        out  1            1-cycle pulse: frame finished cleanly
//   err         out  1            1-cycle pulse: underrun, frame abandoned
//   irq_thresh  in   CNT_W        irq threshold; 0 disables irq
//   irq_clr     in   1            clears irq
//   hit_cnt     out  CNT_W        hits in current/last frame, saturating
//   irq         out  1            level; set when hit_cnt reaches irq_thresh
// BEHAVIOUR
//   Reset: state=IDLE; in_ready,det_x,det_clr_n,done,err,irq=0; hit_cnt=0; busy=0.
//   States: IDLE, LOAD, SHIFT, DRAIN.
//   IDLE: det_clr_n=0 (detector held in s0). start && frame_len!=0 -> LOAD; latch frame_len,
//     clear hit_cnt and irq. start with frame_len==0 ignored (no done, no err).
//   LOAD: in_ready=1; on handshake load shift reg, words_left=frame_len-1 -> SHIFT.
//   SHIFT: det_clr_n=1; det_x=shreg MSB; shift left each clk. On last bit of a word
//     (bit_idx==0): if words_left!=0, in_ready=1; handshake reloads with no bubble;
//     no in_valid -> underrun: err pulse, IDLE, det_clr_n=0 next cycle, hit_cnt kept.
//     Last bit of last word -> DRAIN.
//   DRAIN: one cycle to sample z of final bit; det_x=0; -> IDLE with done=1 next cycle.
//   Hit count: hit_cnt+=1 in every SHIFT/DRAIN cycle with det_z=1; saturates at all-ones.
//   Throughput: LOAD handshake to done = DATA_W*N+2 clks when in_valid never drops.
//   irq: set on the cycle hit_cnt becomes == irq_thresh (thresh!=0); held until irq_clr or
//     accepted start; irq_clr and a same-cycle set -> set wins.
//   abort: highest priority; -> IDLE, no done/err, hit_cnt kept; in_ready=0 that cycle.
//   Only input words handshaked while in_ready=1 are consumed; in_ready=0 in IDLE/DRAIN.
// CONFIGURATION
//   SEQ_CTRL_HIT_POS_EN defined: extra output last_hit_pos [FRAME_LEN_W+$clog2(DATA_W)-1:0]
//     = 1-based frame bit index of the final bit of the most recent hit; cleared on
//     accepted start; reset 0. Undefined: port and bit-position counter absent.
// STRUCTURE
//   seq_ctrl_pkg: state enum (IDLE/LOAD/SHIFT/DRAIN), DATA_W default, bit-index width.
//   Sub-module seq_bit_serializer: shift reg, bit_idx, load/shift, last_bit flag;
//     FSM, hit counter and irq stay in the top.
// TESTING
//   1 word 8'h98, frame_len=1 -> det_x 1,0,0,1,1,0,0,0; hit_cnt=1; done 10 clks after load
//   2 words 8'h9C,8'hE6 back-to-back -> hit_cnt=3 (overlaps); no gap in det_x; done
//   frame_len=2, in_valid low at word boundary -> err pulse, IDLE, det_clr_n=0, hit_cnt=1
//   irq_thresh=2 with 8'h9C,8'hE6 -> irq rises on 2nd hit; irq_clr drops it; 3rd hit no re-set
//   abort mid-SHIFT -> IDLE next clk, no done/err; start with frame_len=0 -> no effect
//   SEQ_CTRL_HIT_POS_EN, 8'h9C,8'hE6 -> last_hit_pos=15; rst mid-frame -> all outputs 0

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types for the 10011 detector sequencer: FSM states, default word width
// and the helper that sizes the serializer bit index.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;

  function automatic int bitIdxW(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// MSB-first word serializer: loads a word, shifts it left once per enabled clock
// and flags the cycle in which the last bit of the word is presented.
module seq_bit_serializer
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_msb,
  output logic              o_last_bit
);

  localparam int IDX_W = bitIdxW(DATA_W);

  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bit_idx;

  // A load on the last bit of a word takes over from the shift, so back-to-back
  // words stream without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else if (i_load) begin
      r_shreg   <= i_data;
      r_bit_idx <= IDX_W'(DATA_W - 1);
    end else if (i_shift) begin
      r_shreg <= r_shreg << 1;
      if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - IDX_W'(1);
    end
  end

  assign o_msb      = r_shreg[DATA_W-1];
  assign o_last_bit = (r_bit_idx == '0);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencer for the 10011 serial detector: streams frame words bit-serially onto det_x,
// owns the detector reset, counts hits and raises irq. Optional: SEQ_CTRL_HIT_POS_EN.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_LEN_W = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   det_x,
  output logic                   det_clr_n,
  input  logic                   det_z,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [CNT_W-1:0]       irq_thresh,
  input  logic                   irq_clr,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic                   irq
`ifdef SEQ_CTRL_HIT_POS_EN
  ,
  output logic [FRAME_LEN_W+$clog2(DATA_W)-1:0] last_hit_pos
`endif
);

  state_t                 r_state;
  logic [FRAME_LEN_W-1:0] r_words_left;
  logic                   r_det_clr_n;
  logic                   r_done;
  logic                   r_err;
  logic [CNT_W-1:0]       r_hit_cnt;
  logic                   r_irq;

  logic             w_msb;
  logic             w_last_bit;
  logic             w_hs;
  logic             w_start_ok;
  logic             w_count;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_irq_set;

  seq_bit_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_hs),
    .i_shift    (r_state == SHIFT),
    .i_data     (in_data),
    .o_msb      (w_msb),
    .o_last_bit (w_last_bit)
  );

  assign in_ready   = !abort && ((r_state == LOAD) ||
                      (r_state == SHIFT && w_last_bit && r_words_left != '0));
  assign w_hs       = in_valid && in_ready;
  assign w_start_ok = (r_state == IDLE) && start && !abort && (frame_len != '0);
  // z lags det_x by one clock, so DRAIN still has a hit to collect.
  assign w_count    = det_z && (r_state == SHIFT || r_state == DRAIN);
  assign w_cnt_next = (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);
  assign w_irq_set  = w_count && (irq_thresh != '0) && (r_hit_cnt != '1) &&
                      (w_cnt_next == irq_thresh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_words_left <= '0;
      r_det_clr_n  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        r_state     <= IDLE;
        r_det_clr_n <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_det_clr_n <= 1'b0;
            if (w_start_ok) begin
              r_state      <= LOAD;
              r_words_left <= frame_len;
            end
          end
          LOAD: begin
            if (w_hs) begin
              r_state      <= SHIFT;
              r_words_left <= r_words_left - FRAME_LEN_W'(1);
              r_det_clr_n  <= 1'b1;
            end
          end
          SHIFT: begin
            if (w_last_bit) begin
              if (r_words_left == '0) begin
                r_state <= DRAIN;
              end else if (w_hs) begin
                r_words_left <= r_words_left - FRAME_LEN_W'(1);
              end else begin
                r_state     <= IDLE;
                r_err       <= 1'b1;
                r_det_clr_n <= 1'b0;
              end
            end
          end
          DRAIN: begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_det_clr_n <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A fresh irq set beats a same-cycle irq_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (w_start_ok) begin
      r_hit_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_count) r_hit_cnt <= w_cnt_next;
      if (w_irq_set) r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
    end
  end

`ifdef SEQ_CTRL_HIT_POS_EN
  localparam int POS_W = FRAME_LEN_W + $clog2(DATA_W);

  logic [POS_W-1:0] r_bit_cnt;
  logic [POS_W-1:0] r_last_hit_pos;

  // r_bit_cnt holds the bits already sent, i.e. the 1-based index of the bit z refers to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt      <= '0;
      r_last_hit_pos <= '0;
    end else if (w_start_ok) begin
      r_bit_cnt      <= '0;
      r_last_hit_pos <= '0;
    end else begin
      if (r_state == SHIFT) r_bit_cnt <= r_bit_cnt + POS_W'(1);
      if (w_count) r_last_hit_pos <= r_bit_cnt;
    end
  end

  assign last_hit_pos = r_last_hit_pos;
`endif

  assign det_x     = (r_state == SHIFT) && w_msb;
  assign det_clr_n = r_det_clr_n;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign hit_cnt   = r_hit_cnt;
  assign irq       = r_irq;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: a bench-side 10011 detector drives det_z; frames are
// checked against a bit-string model of the serial stream, hit count, irq and timing.
module tb_seq_detect_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [7:0]       frame_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             det_x;
  logic             det_clr_n;
  logic             det_z;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] irq_thresh;
  logic             irq_clr;
  logic [CNT_W-1:0] hit_cnt;
  logic             irq;
`ifdef SEQ_CTRL_HIT_POS_EN
  logic [10:0]      last_hit_pos;
`endif

  seq_detect_ctrl #(.DATA_W(8), .FRAME_LEN_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .frame_len  (frame_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .det_x      (det_x),
    .det_clr_n  (det_clr_n),
    .det_z      (det_z),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .irq_thresh (irq_thresh),
    .irq_clr    (irq_clr),
    .hit_cnt    (hit_cnt),
    .irq        (irq)
`ifdef SEQ_CTRL_HIT_POS_EN
    ,
    .last_hit_pos (last_hit_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Moore detector: z is high the cycle after the fifth bit of 10011.
  logic [4:0] dHist;
  logic [4:0] dNext;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dHist <= '0;
      det_z <= 1'b0;
    end else if (!det_clr_n) begin
      dHist <= '0;
      det_z <= 1'b0;
    end else begin
      dNext = {dHist[3:0], det_x};
      dHist <= dNext;
      det_z <= (dNext == 5'b10011);
    end
  end

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] frameWords [0:15];
  bit         gotBits[$];
  bit         expBits[$];
  bit         sawDone, sawErr, irqAfterClr, clrSent;
  int         loadIdx, endIdx, irqRiseHit;
  int         modelHits, modelLastPos;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] wRest;
    int         n;
    int         supply;
    int         thresh;
    int         expHits;
    bit         expDone;
    bit         expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Runs one frame: start, feed `supply` words (in_valid dropped after that), observe at negedge.
  task automatic applyStimulus(input int n, input int supply, input int thresh,
                               input int gap, input bit clrOnIrq);
    int wordIdx = 0;
    int cyc = 0;
    int gapLeft = gap;
    gotBits.delete();
    sawDone = 0; sawErr = 0; loadIdx = -1; endIdx = -1;
    irqRiseHit = -1; irqAfterClr = 0; clrSent = 0;
    @(negedge clk);
    start = 1'b1; frame_len = 8'(n); irq_thresh = CNT_W'(thresh);
    @(negedge clk);
    start = 1'b0;
    while (cyc < 400) begin
      if (busy && loadIdx < 0) loadIdx = cyc;
      if (busy && det_clr_n) gotBits.push_back(det_x);
      if (done || err) begin
        sawDone = done; sawErr = err; endIdx = cyc;
        break;
      end
      irq_clr = 1'b0;
      if (clrOnIrq && irq && !clrSent) begin
        irqRiseHit = int'(hit_cnt);
        irq_clr = 1'b1;
        clrSent = 1;
      end else if (clrSent && irq) begin
        irqAfterClr = 1;
      end
      in_valid = (wordIdx < supply) && (wordIdx > 0 || gapLeft == 0);
      in_data  = frameWords[(wordIdx < 16) ? wordIdx : 15];
      if (busy && gapLeft > 0) gapLeft--;
      #1;
      if (in_valid && in_ready) wordIdx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    irq_clr  = 1'b0;
    checkOutput("frameEnded", int'(sawDone || sawErr), 1);
  endtask

  // Reference: build the expected bit string and count 10011 occurrences in it.
  task automatic checkFrame(input int n, input int supply, input int thresh,
                            input int gap, input bit irqCleared);
    int m, lastEnd, mism;
    bit expDone;
    m = (supply < n) ? supply : n;
    expDone = (supply >= n);
    expBits.delete();
    for (int w = 0; w < m; w++)
      for (int b = 7; b >= 0; b--) expBits.push_back(frameWords[w][b]);
    lastEnd = expDone ? expBits.size() - 1 : expBits.size() - 2;
    modelHits = 0;
    modelLastPos = 0;
    for (int i = 4; i <= lastEnd; i++) begin
      if ({expBits[i-4], expBits[i-3], expBits[i-2], expBits[i-1], expBits[i]} == 5'b10011) begin
        modelHits++;
        modelLastPos = i + 1;
      end
    end
    if (modelHits > CNT_MAX) modelHits = CNT_MAX;
    if (expDone) expBits.push_back(1'b0);
    checkOutput("donePulse", int'(sawDone), int'(expDone));
    checkOutput("errPulse", int'(sawErr), int'(!expDone));
    checkOutput("streamLen", gotBits.size(), expBits.size());
    mism = 0;
    for (int i = 0; i < expBits.size() && i < gotBits.size(); i++)
      if (gotBits[i] != expBits[i]) mism++;
    checkOutput("streamBits", mism, 0);
    checkOutput("hitCnt", int'(hit_cnt), modelHits);
    checkOutput("frameCycles", endIdx - loadIdx, (expDone ? 8 * m + 2 : 8 * m + 1) + gap);
    checkOutput("busyAtEnd", int'(busy), 0);
    if (!irqCleared)
      checkOutput("irqLevel", int'(irq), int'(thresh != 0 && modelHits >= thresh));
`ifdef SEQ_CTRL_HIT_POS_EN
    checkOutput("lastHitPos", int'(last_hit_pos), modelLastPos);
`endif
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] lib [0:5];
    int n, supply, thresh, gap;
    bit seen;
    lib[0] = 8'h9C; lib[1] = 8'hE6; lib[2] = 8'h98;
    lib[3] = 8'h33; lib[4] = 8'h13; lib[5] = 8'h27;

    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    in_valid = 1'b0; in_data = '0; irq_thresh = '0; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", int'(in_ready), 0);
    checkOutput("rstDetClrN", int'(det_clr_n), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstOutputs", int'({det_x, done, err, irq}), 0);
    checkOutput("rstHitCnt", int'(hit_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    vecs.push_back('{8'h98, 8'h00, 1, 1, 0, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h9C, 8'hE6, 2, 2, 0, 3, 1'b1, 1'b0});
    vecs.push_back('{8'h9C, 8'hE6, 2, 1, 0, 1, 1'b0, 1'b0});
    vecs.push_back('{8'h9C, 8'hE6, 2, 2, 4, 3, 1'b1, 1'b0});
    vecs.push_back('{8'h98, 8'h00, 1, 1, 1, 1, 1'b1, 1'b1});
    vecs.push_back('{8'h13, 8'h13, 2, 2, 2, 2, 1'b1, 1'b1});
    vecs.push_back('{8'hFF, 8'h00, 1, 1, 1, 0, 1'b1, 1'b0});
    vecs.push_back('{8'h33, 8'h33, 9, 9, 0, CNT_MAX, 1'b1, 1'b0});

    foreach (vecs[v]) begin
      frameWords[0] = vecs[v].w0;
      for (int w = 1; w < 16; w++) frameWords[w] = vecs[v].wRest;
      applyStimulus(vecs[v].n, vecs[v].supply, vecs[v].thresh, 0, 1'b0);
      checkOutput($sformatf("vec%0d_hits", v), int'(hit_cnt), vecs[v].expHits);
      checkOutput($sformatf("vec%0d_done", v), int'(sawDone), int'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d_irq", v), int'(irq), int'(vecs[v].expIrq));
      checkFrame(vecs[v].n, vecs[v].supply, vecs[v].thresh, 0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_clrIdle", v), int'(det_clr_n), 0);
    end

    // irq rises on the second hit, irq_clr drops it, third hit must not set it again.
    frameWords[0] = 8'h9C; frameWords[1] = 8'hE6;
    applyStimulus(2, 2, 2, 1, 1'b1);
    checkFrame(2, 2, 2, 1, 1'b1);
    checkOutput("irqRiseAtHit", irqRiseHit, 2);
    checkOutput("irqAfterClr", int'(irqAfterClr), 0);
    checkOutput("irqFinal", int'(irq), 0);

    // Abort at a word boundary where in_ready would otherwise be high.
    @(negedge clk);
    start = 1'b1; frame_len = 8'd2; irq_thresh = '0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h9C;
    @(negedge clk);
    in_data = 8'hE6;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    #1;
    checkOutput("abortInReady", int'(in_ready), 0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDetClrN", int'(det_clr_n), 0);
    checkOutput("abortHitKept", int'(hit_cnt), 1);
    seen = done || err;
    repeat (3) begin
      @(negedge clk);
      seen = seen || done || err;
    end
    checkOutput("abortNoDoneErr", int'(seen), 0);

    // start with frame_len==0 is ignored entirely.
    start = 1'b1; frame_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zeroLenBusy", int'(busy), 0);
    seen = done || err;
    repeat (3) begin
      @(negedge clk);
      seen = seen || done || err;
    end
    checkOutput("zeroLenNoPulse", int'(seen), 0);
    checkOutput("zeroLenHitKept", int'(hit_cnt), 1);

    // Reset in the middle of a frame.
    frameWords[0] = 8'h98;
    start = 1'b1; frame_len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h98;
    repeat (4) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstOutputs", int'({in_ready, det_x, det_clr_n, done, err, irq}), 0);
    checkOutput("midRstHitCnt", int'(hit_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized frames, including LOAD gaps and underruns.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 4);
      for (int w = 0; w < 16; w++)
        frameWords[w] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : lib[$urandom_range(0, 5)];
      supply = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : n;
      thresh = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      applyStimulus(n, supply, thresh, gap, 1'b0);
      checkFrame(n, supply, thresh, gap, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
